// File: rtl/inst_sched_pkg.sv
// Shared constants for the round-robin instance scheduler: default sizing
// and the scheduler FSM state encoding.
package inst_sched_pkg;

  localparam int DEF_NUM_INST = 5;
  localparam int DEF_MAX_HOLD = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_GRANT   = 2'd1;
  localparam state_t ST_RELEASE = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-and-priority-encode: finds the first set request bit
// searching upward from ptr, wrapping from NUM_INST-1 back to 0.
module rr_pick
  import inst_sched_pkg::*;
#(
  parameter int NUM_INST = DEF_NUM_INST,
  parameter int IDX_W    = $clog2(NUM_INST)
) (
  input  logic [NUM_INST-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic                found,
  output logic [IDX_W-1:0]    index
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk offsets 0..NUM_INST-1 from ptr; the first hit wins.
  always_comb begin
    found    = 1'b0;
    index    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_INST; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_INST) cand = cand - NUM_INST;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        index = cand_idx;
      end
    end
  end

endmodule

// File: rtl/inst_rr_scheduler.sv
// Round-robin grant of one shared resource among child instances.
// Define SCHED_HOLD_TIMEOUT_EN to build the MAX_HOLD grant revocation.
module inst_rr_scheduler
  import inst_sched_pkg::*;
#(
  parameter int NUM_INST = DEF_NUM_INST,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int IDX_W    = $clog2(NUM_INST)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_INST-1:0] req,
  input  logic [NUM_INST-1:0] done,
  output logic [NUM_INST-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                busy,
  output logic                timeout
);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             rel_normal;
  logic             rel_now;
  logic [IDX_W-1:0] ptr_next;

  rr_pick #(
    .NUM_INST (NUM_INST),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  assign rel_normal = done[grant_idx] | ~req[grant_idx];
  assign ptr_next   = (grant_idx == IDX_W'(NUM_INST - 1)) ? '0 : grant_idx + 1'b1;

`ifdef SCHED_HOLD_TIMEOUT_EN
  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  logic [CNT_W-1:0] hold_cnt;
  logic             hold_hit;

  assign hold_hit = (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign rel_now  = rel_normal | hold_hit;

  // Counter sits at zero outside GRANT so every grant starts fresh; a normal
  // release in the limit cycle takes precedence and suppresses the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout  <= (state == ST_GRANT) && hold_hit && !rel_normal;
      hold_cnt <= ((state == ST_GRANT) && !rel_now) ? hold_cnt + 1'b1 : '0;
    end
  end
`else
  assign rel_now = rel_normal;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      grant     <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant     <= NUM_INST'(1) << pick_idx;
            grant_idx <= pick_idx;
            busy      <= 1'b1;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (rel_now) begin
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= ptr_next;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/inst_rr_scheduler.md
# inst_rr_scheduler

Round-robin scheduler that shares one common resource among the child instances of a generated root module. Each child instance raises a request. The scheduler grants exactly one instance at a time, holds the grant until that instance signals completion, and optionally revokes a grant that overstays a hold limit. It sits beside the child instances inside the root module and drives their one-hot enable.

## Interface
Parameters:
- NUM_INST, 5, number of requesting child instances (valid range 2..32)
- MAX_HOLD, 16, maximum grant length in cycles (used only when the timeout feature is compiled in)
- IDX_W, $clog2(NUM_INST), width of the index output

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_INST  per-instance request, level-sensitive
- done  in  NUM_INST  per-instance completion pulse
- grant  out  NUM_INST  one-hot grant, registered
- grant_idx  out  IDX_W  index of the granted instance; valid while busy=1
- busy  out  1  high while any grant is active
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If req≠0, pick the first set bit searching upward from ptr, wrapping from NUM_INST-1 to 0.
  - Load grant/grant_idx, set busy and go to GRANT.
- GRANT: the grant is released when any of the following occurs:
  - done[grant_idx]=1
  - req[grant_idx]=0
  - the hold counter reaches MAX_HOLD-1 (timeout feature only)
- On release:
  - Clear grant and busy.
  - Set ptr = (grant_idx+1) mod NUM_INST.
  - Go to RELEASE.
- RELEASE: one dead cycle with no grant, then go to IDLE.
- Ignored inputs:
  - done bits for non-granted instances.
  - done while in IDLE or RELEASE.
- Simultaneous done and hold limit in the same cycle: done wins and no timeout pulse is produced.
- Hold counter:
  - Width $clog2(MAX_HOLD).
  - Cleared on entry to GRANT, increments each GRANT cycle.
  - Never wraps, because release happens at MAX_HOLD-1.
- Reset values:
  - state=IDLE, ptr=0, grant=0, grant_idx=0, busy=0, timeout=0, hold counter=0.
- Reset asserted mid-grant: all outputs clear immediately (asynchronous). After reset the next arbitration starts from ptr=0.

## Timing
- Request-to-grant latency: 1 cycle. A req sampled high in IDLE at edge N gives grant high after edge N.
- Done-to-release latency: 1 cycle. grant is low after the edge that samples done.
- Back-to-back grants: minimum 1 idle cycle (RELEASE) between any two grants, including re-grant of the same instance.
- Timeout pulse: high exactly during the RELEASE cycle that follows a revocation.
- Maximum grant length: MAX_HOLD cycles with timeout enabled; unbounded without it.
- Fairness: with all requests held high, every instance is granted once per NUM_INST grants.

## Configuration
- SCHED_HOLD_TIMEOUT_EN defined:
  - The hold counter, MAX_HOLD revocation and the timeout output logic are compiled in.
- SCHED_HOLD_TIMEOUT_EN undefined:
  - No hold counter is built.
  - A grant persists until done or req drop.
  - The timeout port remains and is tied to 0.

## Structure
- Package inst_sched_pkg:
  - State enum (IDLE, GRANT, RELEASE).
  - Default NUM_INST=5 and MAX_HOLD=16 constants.
- Sub-module rr_pick:
  - Purely combinational rotate-and-priority-encode.
  - Inputs: req vector and ptr.
  - Outputs: found and index.
  - Instantiated once by the FSM.

## Test plan
- Reset then req=5'b00100 → grant=5'b00100 and grant_idx=2 one cycle later; done[2] → grant=0 next cycle, grant returns 2 cycles after done if req still high.
- req=5'b11111 held, done pulsed 2 cycles after each grant → grant sequence 0,1,2,3,4,0 with grant_idx wrapping from 4 to 0.
- Granted idx 3, req=5'b01001, done[3] → next grant is idx 0 (wrap past 4), not idx 3.
- Timeout enabled, MAX_HOLD=16, req[1] high and no done → grant held exactly 16 cycles, timeout pulses 1 cycle, then idx 1 is re-granted.
- Timeout enabled, done[1] coincides with the hold limit cycle → grant released, timeout stays 0.
- rst_n driven low during a grant of idx 4 → grant/busy=0 immediately; after release with req=5'b11111, first grant is idx 0.
